// File: rtl/mux151_operand_scan.sv
// mux151_operand_scan
//
// Operand-acquisition stage for the 32-bit adder datapath. It steps a shared
// 3-bit select bus across two banks of external 74151-style 8:1 multiplexers.
// For each select value it reads one nibble from each bank. The nibbles are
// assembled into two 32-bit operands, which are handed downstream with a
// one-cycle finish pulse. Handoff is held back while the downstream stage
// reports busy_nxt.
//
// Parameters:
//   SETTLE_CYC  cycles each select value is held before sampling (3..255)
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   start      asynchronous request; a rising edge starts one scan
//   A0..A3     bank-A mux outputs (A0 = nibble LSB), asynchronous
//   B0..B3     bank-B mux outputs (B0 = nibble LSB), asynchronous
//   busy_nxt   downstream busy; handoff is withheld while high
//   sel_AnB    select bus driven to both mux banks
//   opA, opB   assembled operands, updated only on the handoff edge
//   finish     one-cycle pulse; opA/opB are new in this cycle
//   busy       scan in progress or waiting for handoff
module mux151_operand_scan #(
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        A0,
  input  logic        A1,
  input  logic        A2,
  input  logic        A3,
  input  logic        B0,
  input  logic        B1,
  input  logic        B2,
  input  logic        B3,
  input  logic        busy_nxt,
  output logic [2:0]  sel_AnB,
  output logic [31:0] opA,
  output logic [31:0] opB,
  output logic        finish,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    WAIT_NXT,
    DONE
  } state_e;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  state_e      state_q, state_d;
  logic        start_d1_q, start_d1_d;
  logic        start_d2_q, start_d2_d;
  logic [3:0]  a_meta_q, a_meta_d;
  logic [3:0]  a_sync_q, a_sync_d;
  logic [3:0]  b_meta_q, b_meta_d;
  logic [3:0]  b_sync_q, b_sync_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  sel_q, sel_d;
  logic [31:0] work_a_q, work_a_d;
  logic [31:0] work_b_q, work_b_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        start_tg;

  // start_d2 only ever lags start_d1, so a level held high yields one pulse.
  assign start_tg = start_d1_q & ~start_d2_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    work_a_d   = work_a_q;
    work_b_d   = work_b_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    start_d1_d = start;
    start_d2_d = start_d1_q;
    a_meta_d   = {A3, A2, A1, A0};
    a_sync_d   = a_meta_q;
    b_meta_d   = {B3, B2, B1, B0};
    b_sync_d   = b_meta_q;

    case (state_q)
      IDLE: begin
        sel_d = 3'd0;
        cnt_d = 8'd0;
        if (start_tg) begin
          state_d = SETTLE;
        end
      end

      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      SAMPLE: begin
        for (int k = 0; k < 8; k++) begin
          if (sel_q == 3'(k)) begin
            work_a_d[4*k +: 4] = a_sync_q;
            work_b_d[4*k +: 4] = b_sync_q;
          end
        end
        if (sel_q != 3'd7) begin
          sel_d   = sel_q + 3'd1;
          cnt_d   = 8'd0;
          state_d = SETTLE;
        end else if (!busy_nxt) begin
          // The last nibble is being latched on this same edge, so the
          // handoff must take the freshly merged working value.
          op_a_d  = work_a_d;
          op_b_d  = work_b_d;
          state_d = DONE;
        end else begin
          state_d = WAIT_NXT;
        end
      end

      WAIT_NXT: begin
        if (!busy_nxt) begin
          op_a_d  = work_a_q;
          op_b_d  = work_b_q;
          state_d = DONE;
        end
      end

      DONE: begin
        sel_d   = 3'd0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      start_d1_q <= 1'b0;
      start_d2_q <= 1'b0;
      a_meta_q   <= 4'd0;
      a_sync_q   <= 4'd0;
      b_meta_q   <= 4'd0;
      b_sync_q   <= 4'd0;
      cnt_q      <= 8'd0;
      sel_q      <= 3'd0;
      work_a_q   <= 32'd0;
      work_b_q   <= 32'd0;
      op_a_q     <= 32'd0;
      op_b_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      start_d1_q <= start_d1_d;
      start_d2_q <= start_d2_d;
      a_meta_q   <= a_meta_d;
      a_sync_q   <= a_sync_d;
      b_meta_q   <= b_meta_d;
      b_sync_q   <= b_sync_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      work_a_q   <= work_a_d;
      work_b_q   <= work_b_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
    end
  end

  assign sel_AnB = sel_q;
  assign opA     = op_a_q;
  assign opB     = op_b_q;
  assign finish  = (state_q == DONE);
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mux151_operand_scan.sv
// tb_mux151_operand_scan
//
// Directed bench for mux151_operand_scan. Two instances are used: one with
// SETTLE_CYC = 4 and one with SETTLE_CYC = 3. Each instance has a behavioural
// mux-bank model. The model presents nibble k of its operand roughly 1-2
// cycles after sel_AnB becomes k.
module tb_mux151_operand_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start4, start3;
  logic        busy_nxt4;
  logic        busy_nxt3;
  logic [3:0]  a_in4 = 4'd0, b_in4 = 4'd0, a_in3 = 4'd0, b_in3 = 4'd0;
  logic [2:0]  sel4, sel3;
  logic [31:0] opa4, opb4, opa3, opb3;
  logic        finish4, finish3, busy4, busy3;

  logic [31:0] model_a4 = 32'd0, model_b4 = 32'd0;
  logic [31:0] model_a3 = 32'd0, model_b3 = 32'd0;
  logic [2:0]  sel_prev4 = 3'd0, sel_prev3 = 3'd0;

  int cyc = 0;
  int fin_cnt4 = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  mux151_operand_scan #(.SETTLE_CYC(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .A0(a_in4[0]), .A1(a_in4[1]), .A2(a_in4[2]), .A3(a_in4[3]),
    .B0(b_in4[0]), .B1(b_in4[1]), .B2(b_in4[2]), .B3(b_in4[3]),
    .busy_nxt(busy_nxt4), .sel_AnB(sel4), .opA(opa4), .opB(opb4),
    .finish(finish4), .busy(busy4)
  );

  mux151_operand_scan #(.SETTLE_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .A0(a_in3[0]), .A1(a_in3[1]), .A2(a_in3[2]), .A3(a_in3[3]),
    .B0(b_in3[0]), .B1(b_in3[1]), .B2(b_in3[2]), .B3(b_in3[3]),
    .busy_nxt(busy_nxt3), .sel_AnB(sel3), .opA(opa3), .opB(opb3),
    .finish(finish3), .busy(busy3)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Cycle counter. It changes on the rising edge and is read at negedges.
  always @(posedge clk) cyc <= cyc + 1;

  // Mux-bank models. Each output follows the select value seen one edge
  // earlier, so a new nibble appears one cycle plus 1 time unit after sel
  // changes.
  always @(posedge clk) begin
    #1;
    a_in4 = model_a4[{sel_prev4, 2'b00} +: 4];
    b_in4 = model_b4[{sel_prev4, 2'b00} +: 4];
    sel_prev4 = sel4;
    a_in3 = model_a3[{sel_prev3, 2'b00} +: 4];
    b_in3 = model_b3[{sel_prev3, 2'b00} +: 4];
    sel_prev3 = sel3;
  end

  // Count finish pulses on the S=4 instance.
  always @(negedge clk) if (finish4 === 1'b1) fin_cnt4 = fin_cnt4 + 1;

  // A single comparison, counted and reported on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_cnt++;
    assert (observed === expected) pass_cnt++;
    else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  // Run one complete scan on the chosen instance and check it cycle by cycle.
  // If retrig >= 0, a second start edge is raised on loop step retrig,
  // while the scan is still in progress.
  task automatic applyStimulus(input int s, input logic [31:0] a, input logic [31:0] b,
                               input int retrig);
    int c, per, bad_sel, bad_hold;
    logic [31:0] olda, oldb;
    logic [2:0]  cur_sel;
    logic        cur_busy, cur_fin;
    logic [31:0] cur_a, cur_b;
    per = s + 1;
    bad_sel = 0;
    bad_hold = 0;
    if (s == 3) begin
      model_a3 = a; model_b3 = b; olda = opa3; oldb = opb3; start3 = 1'b1;
    end else begin
      model_a4 = a; model_b4 = b; olda = opa4; oldb = opb4; start4 = 1'b1;
    end
    c = cyc;
    @(negedge clk);
    start3 = 1'b0;
    start4 = 1'b0;
    checkOutput("busy_t0", (s == 3) ? 32'(busy3) : 32'(busy4), 32'd0);
    for (int i = 0; i < 8 * per; i++) begin
      @(negedge clk);
      cur_sel  = (s == 3) ? sel3 : sel4;
      cur_busy = (s == 3) ? busy3 : busy4;
      cur_fin  = (s == 3) ? finish3 : finish4;
      cur_a    = (s == 3) ? opa3 : opa4;
      cur_b    = (s == 3) ? opb3 : opb4;
      if (cur_sel !== 3'(i / per)) bad_sel++;
      if (cur_busy !== 1'b1 || cur_fin !== 1'b0 || cur_a !== olda || cur_b !== oldb)
        bad_hold++;
      if (retrig >= 0 && i == retrig) start4 = 1'b1;
      if (retrig >= 0 && i == retrig + 3) start4 = 1'b0;
    end
    checkOutput("sel_sequence", 32'(bad_sel), 32'd0);
    checkOutput("hold_during_scan", 32'(bad_hold), 32'd0);
    @(negedge clk);
    checkOutput("finish_pulse", (s == 3) ? 32'(finish3) : 32'(finish4), 32'd1);
    checkOutput("finish_latency", 32'(cyc - c), 32'(2 + 8 * per));
    checkOutput("opA_handoff", (s == 3) ? opa3 : opa4, a);
    checkOutput("opB_handoff", (s == 3) ? opb3 : opb4, b);
    checkOutput("busy_in_done", (s == 3) ? 32'(busy3) : 32'(busy4), 32'd1);
    @(negedge clk);
    checkOutput("finish_drop", (s == 3) ? 32'(finish3) : 32'(finish4), 32'd0);
    checkOutput("busy_drop", (s == 3) ? 32'(busy3) : 32'(busy4), 32'd0);
  endtask

  // Directed test sequence.
  initial begin
    int c, n0, bad;
    rst_n = 1'b0;
    start4 = 1'b0;
    start3 = 1'b0;
    busy_nxt4 = 1'b0;
    busy_nxt3 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_sel", 32'(sel4), 32'd0);
    checkOutput("rst_opA", opa4, 32'd0);
    checkOutput("rst_opB", opb4, 32'd0);
    checkOutput("rst_finish", 32'(finish4), 32'd0);
    checkOutput("rst_busy", 32'(busy4), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] basic scan S=4");
    applyStimulus(4, 32'h12345678, 32'h9ABCDEF0, -1);
    repeat (2) @(negedge clk);

    $display("[TB] backpressure");
    model_a4 = 32'hCAFEBABE;
    model_b4 = 32'h0BADF00D;
    start4 = 1'b1;
    c = cyc;
    @(negedge clk);
    start4 = 1'b0;
    busy_nxt4 = 1'b1;
    repeat (40) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sel4 !== 3'd7 || busy4 !== 1'b1 || finish4 !== 1'b0) bad++;
      if (opa4 !== 32'h12345678 || opb4 !== 32'h9ABCDEF0) bad++;
      if (i == 11) busy_nxt4 = 1'b0;
    end
    checkOutput("wait_nxt_hold", 32'(bad), 32'd0);
    @(negedge clk);
    checkOutput("bp_finish", 32'(finish4), 32'd1);
    checkOutput("bp_latency", 32'(cyc - c), 32'd54);
    checkOutput("bp_opA", opa4, 32'hCAFEBABE);
    checkOutput("bp_opB", opb4, 32'h0BADF00D);
    repeat (3) @(negedge clk);

    $display("[TB] start held high");
    n0 = fin_cnt4;
    model_a4 = 32'h0F1E2D3C;
    model_b4 = 32'h4B5A6978;
    start4 = 1'b1;
    repeat (200) @(negedge clk);
    start4 = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("held_finish_count", 32'(fin_cnt4 - n0), 32'd1);
    checkOutput("held_opA", opa4, 32'h0F1E2D3C);
    checkOutput("held_opB", opb4, 32'h4B5A6978);

    $display("[TB] second start during scan");
    n0 = fin_cnt4;
    applyStimulus(4, 32'h87654321, 32'h13579BDF, 20);
    repeat (60) @(negedge clk);
    checkOutput("retrig_finish_count", 32'(fin_cnt4 - n0), 32'd1);
    checkOutput("retrig_idle", 32'(busy4), 32'd0);

    $display("[TB] reset mid-scan");
    model_a4 = 32'hDEADBEEF;
    model_b4 = 32'hFEEDFACE;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (17) @(negedge clk);
    checkOutput("sel_before_reset", 32'(sel4), 32'd3);
    n0 = fin_cnt4;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midrst_opA", opa4, 32'd0);
    checkOutput("midrst_opB", opb4, 32'd0);
    checkOutput("midrst_sel", 32'(sel4), 32'd0);
    checkOutput("midrst_busy", 32'(busy4), 32'd0);
    repeat (50) @(negedge clk);
    checkOutput("midrst_no_finish", 32'(fin_cnt4 - n0), 32'd0);
    applyStimulus(4, 32'h2468ACE0, 32'hFDB97531, -1);
    repeat (2) @(negedge clk);

    $display("[TB] back-to-back scans S=3");
    applyStimulus(3, 32'hFFFFFFFF, 32'h00000000, -1);
    applyStimulus(3, 32'hA5A5A5A5, 32'h5A5A5A5A, -1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
